pc_reg: RTL

//  Program-counter register stage; sits directly downstream of the PC select mux (mx_pc).
//  - Holds the current PC and loads the mux output when control commits a new PC.
//  - Produces PC+INC, which feeds the mux in_ADD input.
//  - Runs the instruction-fetch request/ack handshake, with a watchdog that flags

---
 rtl/pc_reg_pkg.sv | 22 ++
 rtl/pc_reg_if.sv | 29 ++
 rtl/pc_reg_add.sv | 16 +
 rtl/pc_reg.sv | 99 +++++++++
 4 files changed

// File: rtl/pc_reg_pkg.sv
// Shared definitions for the program-counter stage: fetch state encoding
// and parameter defaults.
package pc_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2,
    ST_ERROR = 2'd3
  } pc_state_e;

  localparam int          DEF_WIDTH        = 32;
  localparam logic [63:0] DEF_RESET_VECTOR = 64'd0;
  localparam int          DEF_INC          = 1;
  localparam int          DEF_TIMEOUT      = 15;

  // A zero TIMEOUT disables the watchdog; keep the counter at least one bit wide.
  function automatic int wd_cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/pc_reg_if.sv
// Control / instruction-memory bundle of the PC stage. The slave side is the
// PC register itself, the master side is control plus instruction memory.
interface pc_reg_if
  import pc_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic [WIDTH-1:0] in_PC;
  logic             W_PC;
  logic             stall;
  logic             imem_ack;
  logic             imem_req;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PC_ADD;
  logic             instr_valid;
  logic             fetch_err;

  modport master (
    output in_PC, W_PC, stall, imem_ack,
    input  imem_req, PC, PC_ADD, instr_valid, fetch_err
  );

  modport slave (
    input  in_PC, W_PC, stall, imem_ack,
    output imem_req, PC, PC_ADD, instr_valid, fetch_err
  );

endinterface

// File: rtl/pc_reg_add.sv
// Sequential-address incrementer: PC + INC, wrapping modulo 2^WIDTH.
module pc_add
  import pc_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int INC   = DEF_INC
) (
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_inc
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  assign pc_inc = pc + INC_W;

endmodule

// File: rtl/pc_reg.sv
// Program-counter register stage: holds the PC, runs the fetch request/ack
// handshake and flags instruction-memory timeouts.
module pc_reg
  import pc_reg_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter int               INC          = DEF_INC,
  parameter int               TIMEOUT      = DEF_TIMEOUT
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_reg_if.slave  bus
);

  localparam int             CW       = wd_cnt_width(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam bit             WD_EN    = (TIMEOUT > 0);

  pc_state_e        state_r, state_nxt_s;
  logic [WIDTH-1:0] pc_r, pc_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             imem_req_r, instr_valid_r, fetch_err_r;
  logic [WIDTH-1:0] pc_add_s;

  pc_add #(
    .WIDTH (WIDTH),
    .INC   (INC)
  ) u_pc_add (
    .pc     (pc_r),
    .pc_inc (pc_add_s)
  );

  // Next-state, next-PC and watchdog decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    cnt_nxt_s   = '0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ack) begin
          state_nxt_s = ST_READY;
        end else if (WD_EN && (cnt_r == CNT_LAST)) begin
          state_nxt_s = ST_ERROR;
        end else if (WD_EN) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = '0;
        end
      end
      ST_READY: begin
        // A load requested under stall is dropped, not queued.
        if (bus.W_PC && !bus.stall) begin
          pc_nxt_s    = bus.in_PC;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      ST_ERROR: begin
        state_nxt_s = ST_ERROR;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, PC, watchdog and flag registers; flags decode the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_VECTOR;
      cnt_r         <= '0;
      imem_req_r    <= 1'b0;
      instr_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      pc_r          <= pc_nxt_s;
      cnt_r         <= cnt_nxt_s;
      imem_req_r    <= (state_nxt_s == ST_FETCH);
      instr_valid_r <= (state_nxt_s == ST_READY);
      fetch_err_r   <= (state_nxt_s == ST_ERROR);
    end
  end

  assign bus.PC          = pc_r;
  assign bus.PC_ADD      = pc_add_s;
  assign bus.imem_req    = imem_req_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.fetch_err   = fetch_err_r;

endmodule
